// File: rtl/fp_common_pkg.sv
// Shared FPU definitions: exponent width, exponent field type and datapath branch encoding.
package fp_common_pkg;

    localparam int unsigned EXP_W = 5;

    typedef logic [EXP_W-1:0] exp_t;

    // Branch index carried on the demux select line.
    localparam logic BR_ADD = 1'b0;
    localparam logic BR_MUL = 1'b1;

    typedef enum logic {
        StEmpty,
        StFull
    } br_state_e;

endpackage

// File: rtl/demux_branch_reg.sv
// One demux output branch: a one-entry valid/ready register plus an accepted-word counter.
module demux_branch_reg
    import fp_common_pkg::*;
#(
    parameter int unsigned WIDTH = EXP_W,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             free_o,
    output logic [CNT_W-1:0] cnt_o
);

    br_state_e        state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StEmpty: begin
                if (load_i) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                if (ready_i && !load_i) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
        // Data only moves on a load, so it holds its last word after draining.
        if (load_i) begin
            data_d = data_i;
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StEmpty;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_o = (state_q == StFull);
    assign free_o  = (state_q == StEmpty) || ready_i;
    assign data_o  = data_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/demux_1_2_5_bits_reg.sv
// Registered 1:2 demux steering exponent/shift-amount words to the add/sub or mul branch.
module demux_1_2_5_bits_reg
    import fp_common_pkg::*;
#(
    parameter int unsigned WIDTH = EXP_W,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_select,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_0_data,
    output logic             out_0_valid,
    input  logic             out_0_ready,
    output logic [WIDTH-1:0] out_1_data,
    output logic             out_1_valid,
    input  logic             out_1_ready,
    output logic [CNT_W-1:0] cnt_0,
    output logic [CNT_W-1:0] cnt_1
);

    logic free_0, free_1;
    logic accept;
    logic load_0, load_1;

    // Readiness reflects only the selected branch, never in_valid.
    assign in_ready = (in_select == BR_MUL) ? free_1 : free_0;
    assign accept   = in_valid && in_ready;
    assign load_0   = accept && (in_select == BR_ADD);
    assign load_1   = accept && (in_select == BR_MUL);

    demux_branch_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_branch_add (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .load_i  (load_0),
        .data_i  (in_data),
        .ready_i (out_0_ready),
        .valid_o (out_0_valid),
        .data_o  (out_0_data),
        .free_o  (free_0),
        .cnt_o   (cnt_0)
    );

    demux_branch_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_branch_mul (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .load_i  (load_1),
        .data_i  (in_data),
        .ready_i (out_1_ready),
        .valid_o (out_1_valid),
        .data_o  (out_1_data),
        .free_o  (free_1),
        .cnt_o   (cnt_1)
    );

endmodule

// File: tb/tb_demux_1_2_5_bits_reg.sv
// Randomised self-checking bench for demux_1_2_5_bits_reg against a queue-based branch model.
module tb_demux_1_2_5_bits_reg;
    import fp_common_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] in_data = '0;
    logic       in_select = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] out_0_data, out_1_data;
    logic       out_0_valid, out_1_valid;
    logic       out_0_ready = 1'b0;
    logic       out_1_ready = 1'b0;
    logic [7:0] cnt_0, cnt_1;

    int checks = 0;
    int failures = 0;

    // Reference model: each branch is a queue holding at most one word.
    logic [4:0] mq0[$];
    logic [4:0] mq1[$];
    logic [4:0] last0, last1;
    logic [7:0] mc0, mc1;

    always #5 clk = ~clk;

    demux_1_2_5_bits_reg #(
        .WIDTH (5),
        .CNT_W (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_select   (in_select),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_0_data  (out_0_data),
        .out_0_valid (out_0_valid),
        .out_0_ready (out_0_ready),
        .out_1_data  (out_1_data),
        .out_1_valid (out_1_valid),
        .out_1_ready (out_1_ready),
        .cnt_0       (cnt_0),
        .cnt_1       (cnt_1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq0.delete();
        mq1.delete();
        last0 = '0;
        last1 = '0;
        mc0 = '0;
        mc1 = '0;
    endtask

    task automatic check_outputs();
        check_eq("out_0_valid", 32'(out_0_valid), 32'(mq0.size() != 0));
        check_eq("out_1_valid", 32'(out_1_valid), 32'(mq1.size() != 0));
        check_eq("out_0_data", 32'(out_0_data), 32'(last0));
        check_eq("out_1_data", 32'(out_1_data), 32'(last1));
        check_eq("cnt_0", 32'(cnt_0), 32'(mc0));
        check_eq("cnt_1", 32'(cnt_1), 32'(mc1));
    endtask

    // Called just after a falling edge: drive, check, then advance one clock.
    task automatic step(input logic v, input logic sel, input logic [4:0] d,
                        input logic r0, input logic r1);
        logic exp_rdy;
        logic acc;
        in_valid    = v;
        in_select   = sel;
        in_data     = d;
        out_0_ready = r0;
        out_1_ready = r1;
        #1;
        exp_rdy = sel ? (mq1.size() == 0 || r1) : (mq0.size() == 0 || r0);
        check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
        check_outputs();
        acc = v && exp_rdy;
        @(posedge clk);
        if (mq0.size() != 0 && r0) void'(mq0.pop_front());
        if (mq1.size() != 0 && r1) void'(mq1.pop_front());
        if (acc) begin
            if (sel) begin
                mq1.push_back(d);
                last1 = d;
                mc1++;
            end else begin
                mq0.push_back(d);
                last0 = d;
                mc0++;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 5'h1B;
        #1;
        model_clear();
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
    endtask

    initial begin
        model_clear();
        @(negedge clk);
        do_reset();
        // No spurious output after release.
        step(1'b0, 1'b0, 5'h00, 1'b1, 1'b1);
        step(1'b0, 1'b1, 5'h00, 1'b1, 1'b1);

        // Routing
        step(1'b1, BR_ADD, 5'h1F, 1'b1, 1'b1);
        step(1'b1, BR_MUL, 5'h0A, 1'b1, 1'b1);
        check_eq("route_out_1", 32'(out_1_data), 32'h0A);
        step(1'b0, 1'b0, 5'h00, 1'b1, 1'b1);
        check_eq("route_cnt_0", 32'(cnt_0), 32'd1);
        check_eq("route_cnt_1", 32'(cnt_1), 32'd1);

        // Backpressure on branch 0
        step(1'b1, BR_ADD, 5'h03, 1'b0, 1'b1);
        step(1'b1, BR_ADD, 5'h04, 1'b0, 1'b1);
        check_eq("bp_hold_data", 32'(out_0_data), 32'h03);
        check_eq("bp_not_ready", 32'(in_ready), 32'd0);
        step(1'b1, BR_ADD, 5'h04, 1'b1, 1'b1);
        check_eq("bp_deliver", 32'(out_0_data), 32'h04);
        check_eq("bp_cnt_0", 32'(cnt_0), 32'd3);

        // Branch 0 stalled full while branch 1 keeps accepting
        step(1'b1, BR_MUL, 5'h11, 1'b0, 1'b1);
        check_eq("ind_out_1", 32'(out_1_data), 32'h11);
        check_eq("ind_out_0", 32'(out_0_data), 32'h04);
        check_eq("ind_valid_0", 32'(out_0_valid), 32'd1);
        step(1'b0, BR_ADD, 5'h00, 1'b0, 1'b1);

        // Back-to-back alternating stream
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, logic'(i % 2), 5'(i + 3), 1'b1, 1'b1);
        end
        check_eq("stream_cnt_0", 32'(cnt_0), 32'd5);
        check_eq("stream_cnt_1", 32'(cnt_1), 32'd5);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
        end

        // Counter wrap on branch 1
        do_reset();
        for (int i = 0; i < 256; i++) begin
            step(1'b1, BR_MUL, 5'($urandom), 1'b1, 1'b1);
        end
        check_eq("wrap_cnt_1", 32'(cnt_1), 32'd0);
        step(1'b0, BR_ADD, 5'h00, 1'b1, 1'b0);
        check_eq("wrap_valid_1", 32'(out_1_valid), 32'd1);

        // Reset mid-stream, away from a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid_1", 32'(out_1_valid), 32'd0);
        check_eq("midrst_cnt_1", 32'(cnt_1), 32'd0);
        check_eq("midrst_data_1", 32'(out_1_data), 32'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, BR_MUL, 5'h00, 1'b1, 1'b1);
        step(1'b1, BR_MUL, 5'h07, 1'b1, 1'b1);
        step(1'b0, BR_MUL, 5'h00, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
